// File: rtl/linear_layer_sequencer.sv
// Streams one pass of M weight rows (N weights + bias each) from a 1-cycle-latency BRAM to the MAC array.
// Optional `LINEAR_SEQ_STALL_CNT_EN adds a stall_cycles output counting backpressured cycles per pass.
module linear_layer_sequencer #(
  parameter int M              = 5,
  parameter int N              = 5,
  parameter int PRECISION      = 5,
  parameter int BIAS_PRECISION = 32,
  parameter int BRAM_WIDTH     = N*PRECISION+BIAS_PRECISION
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_en,
  output logic [$clog2(M)-1:0]          mem_addr,
  input  logic [BRAM_WIDTH-1:0]         mem_dout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N*PRECISION-1:0]        out_weights,
  output logic [BIAS_PRECISION-1:0]     out_bias,
  output logic [$clog2(M)-1:0]          out_row,
  output logic                          out_last
`ifdef LINEAR_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int ROW_W = $clog2(M);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M-1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [N*PRECISION-1:0]    weights;
    logic [BIAS_PRECISION-1:0] bias;
    logic [ROW_W-1:0]          row;
    logic                      last;
  } entry_t;

  state_t           state_q;
  logic [ROW_W-1:0] addr_q;
  logic             busy_q;
  logic             done_q;

  entry_t           fifo_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic             inflight_q;
  logic [ROW_W-1:0] inflight_row_q;

  logic             push;
  logic             pop;
  logic             issue;
  logic [2:0]       credit_sum;
  entry_t           head;

  // Credit counts rows already committed to the buffer (stored or in flight),
  // so a read is only issued when a slot is guaranteed free on arrival.
  always_comb begin
    pop        = out_valid & out_ready;
    push       = inflight_q;
    credit_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == FETCH) && (credit_sum < 3'd2);
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    head       = fifo_q[rd_ptr_q];
  end

  assign mem_en      = issue;
  assign mem_addr    = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign out_valid   = (occ_q != 2'd0);
  assign out_weights = head.weights;
  assign out_bias    = head.bias;
  assign out_row     = head.row;
  assign out_last    = head.last;

  // NOTE: sequential state uses non-blocking assignments only; combinational
  // values above use blocking assignments with every output assigned each pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (issue) begin
            if (addr_q == LAST_ROW) begin
              state_q <= DRAIN;
              addr_q  <= '0;
            end else begin
              addr_q  <= addr_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The last row leaves with nothing behind it: the pass is complete.
          if (pop && (occ_q == 2'd1) && !inflight_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the two buffer entries are reset because their contents drive the
  // out_* ports directly and must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
      inflight_q     <= 1'b0;
      inflight_row_q <= '0;
    end else begin
      inflight_q     <= issue;
      inflight_row_q <= addr_q;
      if (push) begin
        fifo_q[wr_ptr_q] <= '{weights: mem_dout[N*PRECISION-1:0],
                               bias:    mem_dout[N*PRECISION +: BIAS_PRECISION],
                               row:     inflight_row_q,
                               last:    (inflight_row_q == LAST_ROW)};
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && (occ_q == 2'd2)));

`ifdef LINEAR_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (busy_q && out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_linear_layer_sequencer.sv
// Directed bench for linear_layer_sequencer: BRAM model, ready patterns, mid-pass reset, ignored start.
`timescale 1ns/1ps
module tb_linear_layer_sequencer;

  localparam int M  = 5;
  localparam int N  = 5;
  localparam int P  = 5;
  localparam int BP = 32;
  localparam int BW = N*P+BP;
  localparam int RW = $clog2(M);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic [RW-1:0] mem_addr;
  logic [BW-1:0] mem_dout;
  logic          out_valid;
  logic          out_ready;
  logic [N*P-1:0] out_weights;
  logic [BP-1:0] out_bias;
  logic [RW-1:0] out_row;
  logic          out_last;
`ifdef LINEAR_SEQ_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  linear_layer_sequencer #(.M(M), .N(N), .PRECISION(P), .BIAS_PRECISION(BP), .BRAM_WIDTH(BW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_dout    (mem_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_weights (out_weights),
    .out_bias    (out_bias),
    .out_row     (out_row),
    .out_last    (out_last)
`ifdef LINEAR_SEQ_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Row r: weight i = (r+i) mod 32, bias = 0x1000 + r.
  function automatic logic [N*P-1:0] exp_weights(input int r);
    logic [N*P-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[i*P +: P] = P'((r + i) % 32);
    return w;
  endfunction

  function automatic logic [BP-1:0] exp_bias(input int r);
    return BP'(32'h1000 + r);
  endfunction

  always @(posedge clk) begin
    if (mem_en) mem_dout <= {exp_bias(int'(mem_addr)), exp_weights(int'(mem_addr))};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},      busy,        0);
    check({pfx, "_done"},      done,        0);
    check({pfx, "_mem_en"},    mem_en,      0);
    check({pfx, "_mem_addr"},  mem_addr,    0);
    check({pfx, "_out_valid"}, out_valid,   0);
    check({pfx, "_weights"},   out_weights, 0);
    check({pfx, "_bias"},      out_bias,    0);
    check({pfx, "_row"},       out_row,     0);
    check({pfx, "_last"},      out_last,    0);
  endtask

  // mode 0: ready always high; 1: low in cycles 3..8; 2: toggling 1,0,1,0...
  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      1:       return !(c >= 3 && c <= 8);
      2:       return (c % 2) == 1;
      default: return 1'b1;
    endcase
  endfunction

  // Start sampled at "edge 0"; cycle c lies between edge c-1 and edge c.
  task automatic run_pass(input string name, input int mode, input int exp_done, input bit poke_start);
    int next_row = 0;
    int hs = 0;
    int dones = 0;
    int done_cyc = -1;
    bit held = 0;
    logic [N*P-1:0] hold_w = '0;
    logic [BP-1:0]  hold_b = '0;
    logic [RW-1:0]  hold_r = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      out_ready = ready_for(mode, c);
      start = poke_start && (c == 4);
      @(negedge clk);
      if (mode == 0 && c == 1) begin
        check({name, "_mem_en_c1"},   mem_en,   1);
        check({name, "_mem_addr_c1"}, mem_addr, 0);
      end
      if (mode == 0 && c == 2) check({name, "_valid_c2"}, out_valid, 0);
      if (mode == 0 && c == 3) check({name, "_valid_c3"}, out_valid, 1);
      if (held) begin
        check({name, "_hold_valid"},   out_valid,   1);
        check({name, "_hold_weights"}, out_weights, hold_w);
        check({name, "_hold_bias"},    out_bias,    hold_b);
        check({name, "_hold_row"},     out_row,     hold_r);
      end
      if (out_valid && out_ready) begin
        check({name, "_row"},     out_row,     next_row);
        check({name, "_weights"}, out_weights, exp_weights(next_row));
        check({name, "_bias"},    out_bias,    exp_bias(next_row));
        check({name, "_last"},    out_last,    next_row == M-1);
        next_row++;
        hs++;
      end
      held   = out_valid && !out_ready;
      hold_w = out_weights;
      hold_b = out_bias;
      hold_r = out_row;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc < 0 || c == done_cyc) check({name, "_busy_high"}, busy, 1);
      if (done_cyc > 0 && c == done_cyc + 1) check({name, "_busy_fall"}, busy, 0);
      if (done_cyc > 0 && c >= done_cyc + 2) break;
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({name, "_handshakes"}, hs,    M);
    check({name, "_done_count"}, dones, 1);
    if (exp_done > 0) check({name, "_done_cycle"}, done_cyc, exp_done);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_pass("full_rate", 0, M+3, 1'b0);

    run_pass("stall6", 1, 14, 1'b0);
`ifdef LINEAR_SEQ_STALL_CNT_EN
    check("stall_cycles_6", stall_cycles, 6);
`endif

    run_pass("toggle", 2, -1, 1'b0);

    run_pass("start_ignored", 0, M+3, 1'b1);
`ifdef LINEAR_SEQ_STALL_CNT_EN
    check("stall_cycles_cleared", stall_cycles, 0);
`endif
    repeat (4) @(negedge clk);
    check("idle_after_ignored_start", busy, 0);

    // Mid-pass reset while row 2 is presented.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    begin
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (out_valid && out_row == 2) seen = 1;
      end
      check("reset_row2_reached", seen, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midpass_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    check("no_done_after_reset", done, 0);

    run_pass("after_reset", 0, M+3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
